jt10_adpcma_acc: RTL and testbench
==================================

Name: jt10_adpcma_acc

Overview:
ADPCM-A decode back end for the YM2610 ADPCM-A path. It sits directly downstream of the step/delta increment LUT and is time-multiplexed over 6 channels.
- Accepts one 4-bit ADPCM nibble per request and drives the LUT address {step, delta}.
- Consumes the registered increment, then updates the per-channel 12-bit accumulator and step index.
- Emits one signed 12-bit PCM sample per nibble to the channel mixer.

Parameters:
CH_NUM, 6, number of channels with stored state; valid ch values are 0..CH_NUM-1
STEP_MAX, 48, maximum step index; the LUT holds steps 0..STEP_MAX

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cen  in  1  clock enable; all state advances only on clk edges with cen=1
clr  in  1  clear request for channel clr_ch
clr_ch  in  3  channel to clear
nibble_valid  in  1  nibble request valid
nibble  in  4  bit3 = sign, bits2:0 = delta magnitude
ch  in  3  channel of the nibble
nibble_ready  out  1  request accepted on a cen edge when valid and ready are both 1
lut_addr  out  9  {step[5:0], delta[2:0]} to the increment LUT
lut_inc  in  12  unsigned increment, registered by the LUT one cen edge after lut_addr
pcm_valid  out  1  new sample present
pcm  out  12  signed two's-complement sample
pcm_ch  out  3  channel of pcm

Behaviour:
- Reset: FSM=IDLE; all acc and step entries = 0; lut_addr=0; pcm=0; pcm_ch=0; pcm_valid=0; internal latches=0.
- State storage: CH_NUM x {acc[11:0], step[5:0]} in flops, not RAM.
- FSM IDLE -> ADDR -> ACC -> IDLE; every transition occurs only on a cen edge.
- IDLE:
  - nibble_ready=1.
  - On a cen edge with nibble_valid=1: latch ch and nibble; register lut_addr <= {step[ch], nibble[2:0]}; go to ADDR.
  - ch >= CH_NUM: request is accepted, then dropped (no writeback, no pcm_valid).
- ADDR: nibble_ready=0; the LUT captures lut_addr on this cen edge; go to ACC.
- ACC:
  - nibble_ready=0; lut_inc is valid.
  - sum = acc ± inc: sign-extend to 13 bits; subtract when nibble[3]=1.
  - Default: wrap to 12 bits (keep sum[11:0]).
  - new step = step + adj[delta], adj = {-1,-1,-1,-1,+2,+5,+7,+9}, clamped to 0..STEP_MAX.
  - On the cen edge: write acc and step back, pcm <= new acc, pcm_ch <= ch, pcm_valid <= 1, go to IDLE.
- pcm_valid: high for exactly one cen-qualified cycle, cleared at the next cen edge. pcm and pcm_ch hold until the next sample.
- Latency and throughput: accept at cen edge k -> pcm_valid=1 after edge k+2. Throughput is 1 nibble per 3 cen edges.
- clr: on a cen edge with clr=1 and clr_ch < CH_NUM, acc[clr_ch]=0 and step[clr_ch]=0.
  - If clr_ch matches the in-flight channel (ADDR/ACC), the in-flight result is discarded: no writeback, no pcm_valid, FSM still returns to IDLE.
  - clr in the same edge as an ACC writeback to that channel: clr wins.
  - clr on the same edge as an accept for the same channel: the accept uses the pre-clear step; its result is then discarded.
- cen=0: all registers hold, including pcm_valid.
- rst_n low mid-operation: immediate return to reset values; the in-flight nibble is lost.

Optional Feature:
JT10_ADPCMA_SAT_EN
- Defined: ACC saturates the 13-bit sum to +2047 (12'h7FF) / -2048 (12'h800) instead of wrapping.
- Undefined: 12-bit wrap-around, which matches chip behaviour.
- Step adaptation and timing are identical either way.

Test Plan:
- Reset, then ch0 nibble 4'h7 -> lut_addr 9'o00_7; with inc=30, pcm=12'd30, pcm_ch=0, step[0]=9, pcm_valid 2 cen edges after accept.
- Then ch0 nibble 4'hF -> lut_addr 9'o11_7; with inc=69, pcm=12'hFD9 (-39), step[0]=18.
- Reset, ch2 nibble 4'h0 -> inc 2, pcm=2, step stays 0 (clamp at 0, no underflow).
- Six ch1 nibbles 4'h7 from reset:
  - incs 30,69,165,391,926,2186; step sequence 9,18,27,36,45,48 (clamped).
  - Final pcm=12'hEB7 (-329) wrapped; 12'h7FF with JT10_ADPCMA_SAT_EN.
  - ch0 state unchanged throughout.
- clr ch1 asserted during its ACC state -> no pcm_valid for that nibble.
  - The next ch1 nibble 4'h0 gives pcm=2, lut_addr 9'o00_0.
  - An interleaved ch0 nibble continues from its prior state.
- cen toggled 1-of-3 with back-to-back nibble_valid:
  - nibble_ready low in ADDR/ACC; exactly one pcm_valid per accepted nibble.
  - ch=7 accepted but produces no pcm_valid.
  - rst_n pulsed mid-ACC -> pcm_valid stays 0 and all state reads back 0.

Source files
------------

// File: rtl/jt10_adpcma_acc_if.sv
// Request / LUT / sample bundle for the ADPCM-A accumulator back end.
// slave = the accumulator, master = sequencer + LUT + mixer side.
interface jt10_adpcma_acc_if;
  logic        clr;
  logic [2:0]  clr_ch;
  logic        nibble_valid;
  logic [3:0]  nibble;
  logic [2:0]  ch;
  logic        nibble_ready;
  logic [8:0]  lut_addr;
  logic [11:0] lut_inc;
  logic        pcm_valid;
  logic [11:0] pcm;
  logic [2:0]  pcm_ch;

  modport slave (
    input  clr, clr_ch, nibble_valid, nibble, ch, lut_inc,
    output nibble_ready, lut_addr, pcm_valid, pcm, pcm_ch
  );

  modport master (
    output clr, clr_ch, nibble_valid, nibble, ch, lut_inc,
    input  nibble_ready, lut_addr, pcm_valid, pcm, pcm_ch
  );
endinterface

// File: rtl/jt10_adpcma_acc.sv
// YM2610 ADPCM-A accumulator/step back end, time-multiplexed over CH_NUM channels.
// Optional JT10_ADPCMA_SAT_EN: saturate the accumulator instead of 12-bit wrap.

// Per-channel {acc, step} storage; clear takes priority over writeback.
module jt10_adpcma_acc_ch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_en,
  input  logic        wr_en,
  input  logic [11:0] acc_d,
  input  logic [5:0]  step_d,
  output logic [11:0] acc_q,
  output logic [5:0]  step_q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      step_q <= '0;
    end else if (clr_en) begin
      acc_q  <= '0;
      step_q <= '0;
    end else if (wr_en) begin
      acc_q  <= acc_d;
      step_q <= step_d;
    end
  end
endmodule

module jt10_adpcma_acc #(
  parameter int CH_NUM   = 6,
  parameter int STEP_MAX = 48
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  jt10_adpcma_acc_if.slave bus
);
  localparam logic [3:0]        CH_LIM   = 4'(CH_NUM);
  localparam logic signed [7:0] STEP_LIM = 8'(STEP_MAX);

  typedef enum logic [1:0] {IDLE, ADDR, ACC} state_t;
  state_t state_q, state_d;

  logic [CH_NUM-1:0][11:0] acc_q;
  logic [CH_NUM-1:0][5:0]  step_q;
  logic [CH_NUM-1:0]       clr_en, wr_en;

  logic [2:0]  ch_q;
  logic [3:0]  nibble_q;
  logic        live_q;     // in-flight result still allowed to write back
  logic [11:0] cur_acc, new_acc;
  logic [5:0]  cur_step, in_step, new_step;
  logic signed [7:0] adj, step_sum;
  logic        ready, clr_hit, wb, ch_ok;

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (cen && bus.nibble_valid) state_d = ADDR;
      end
      ADDR:    if (cen) state_d = ACC;
      ACC:     if (cen) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.nibble_ready = ready;

  // channel state mux: in-flight channel and newly requested channel
  always_comb begin
    cur_acc  = '0;
    cur_step = '0;
    in_step  = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch_q == 3'(i)) begin
        cur_acc  = acc_q[i];
        cur_step = step_q[i];
      end
      if (bus.ch == 3'(i)) in_step = step_q[i];
    end
  end

  assign ch_ok   = {1'b0, bus.ch} < CH_LIM;
  assign clr_hit = bus.clr && (bus.clr_ch == ch_q);
  assign wb      = (state_q == ACC) && live_q && !clr_hit;

  // step adaptation with clamp to 0..STEP_MAX
  always_comb begin
    case (nibble_q[2:0])
      3'd4:    adj = 8'sd2;
      3'd5:    adj = 8'sd5;
      3'd6:    adj = 8'sd7;
      3'd7:    adj = 8'sd9;
      default: adj = -8'sd1;
    endcase
    step_sum = $signed({2'b00, cur_step}) + adj;
    if (step_sum < 8'sd0)          new_step = '0;
    else if (step_sum > STEP_LIM)  new_step = STEP_LIM[5:0];
    else                           new_step = step_sum[5:0];
  end

`ifdef JT10_ADPCMA_SAT_EN
  logic signed [13:0] acc_ext, inc_ext, sum;
  always_comb begin
    acc_ext = {{2{cur_acc[11]}}, cur_acc};
    inc_ext = {2'b00, bus.lut_inc};
    sum     = nibble_q[3] ? (acc_ext - inc_ext) : (acc_ext + inc_ext);
    if (sum > 14'sd2047)       new_acc = 12'h7FF;
    else if (sum < -14'sd2048) new_acc = 12'h800;
    else                       new_acc = sum[11:0];
  end
`else
  // low 12 bits of the extended sum are the plain 12-bit sum
  assign new_acc = nibble_q[3] ? (cur_acc - bus.lut_inc) : (cur_acc + bus.lut_inc);
`endif

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      clr_en[i] = cen && bus.clr && (bus.clr_ch == 3'(i));
      wr_en[i]  = cen && wb && (ch_q == 3'(i));
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    jt10_adpcma_acc_ch u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_en (clr_en[g]),
      .wr_en  (wr_en[g]),
      .acc_d  (new_acc),
      .step_d (new_step),
      .acc_q  (acc_q[g]),
      .step_q (step_q[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q          <= '0;
      nibble_q      <= '0;
      live_q        <= 1'b0;
      bus.lut_addr  <= '0;
      bus.pcm       <= '0;
      bus.pcm_ch    <= '0;
      bus.pcm_valid <= 1'b0;
    end else if (cen) begin
      bus.pcm_valid <= 1'b0;
      case (state_q)
        IDLE: if (bus.nibble_valid) begin
          ch_q         <= bus.ch;
          nibble_q     <= bus.nibble;
          bus.lut_addr <= {in_step, bus.nibble[2:0]};
          // same-edge clear of this channel: address uses pre-clear step, result dropped
          live_q       <= ch_ok && !(bus.clr && (bus.clr_ch == bus.ch));
        end
        ADDR: if (clr_hit) live_q <= 1'b0;
        ACC: begin
          live_q <= 1'b0;
          if (wb) begin
            bus.pcm       <= new_acc;
            bus.pcm_ch    <= ch_q;
            bus.pcm_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jt10_adpcma_acc.sv
// Directed bench for jt10_adpcma_acc; the LUT increment is driven by hand per nibble.
module tb_jt10_adpcma_acc;
  logic clk, rst_n, cen;
  int   n_cmp, n_err;

  jt10_adpcma_acc_if bus();
  jt10_adpcma_acc dut (.clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus));

`ifdef JT10_ADPCMA_SAT_EN
  localparam logic [11:0] BIG = 12'h7FF;
`else
  localparam logic [11:0] BIG = 12'hEB7;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  // One nibble with cen=1 every edge; clr_at selects accept(1)/ADDR(2)/ACC(3) edge for clr.
  task automatic send(input logic [2:0] c, input logic [3:0] nib, input logic [11:0] inc,
                      input logic [8:0] e_addr, input logic [11:0] e_pcm, input logic e_vld,
                      input int clr_at, input logic [2:0] cch);
    chk("ready_idle", 12'(bus.nibble_ready), 12'd1);
    bus.nibble_valid = 1'b1; bus.ch = c; bus.nibble = nib; bus.lut_inc = inc;
    bus.clr = (clr_at == 1); bus.clr_ch = cch;
    cyc();
    bus.nibble_valid = 1'b0; bus.clr = (clr_at == 2);
    chk("lut_addr", 12'(bus.lut_addr), 12'(e_addr));
    chk("ready_addr", 12'(bus.nibble_ready), 12'd0);
    chk("vld_k", 12'(bus.pcm_valid), 12'd0);
    cyc();
    bus.clr = (clr_at == 3);
    chk("ready_acc", 12'(bus.nibble_ready), 12'd0);
    chk("vld_k1", 12'(bus.pcm_valid), 12'd0);
    cyc();
    bus.clr = 1'b0;
    chk("vld_k2", 12'(bus.pcm_valid), 12'(e_vld));
    if (e_vld) begin
      chk("pcm", bus.pcm, e_pcm);
      chk("pcm_ch", 12'(bus.pcm_ch), 12'(c));
    end
  endtask

  logic [2:0]  rq_ch [4] = '{3'd0, 3'd7, 3'd0, 3'd3};
  logic [2:0]  ex_ch [3] = '{3'd0, 3'd0, 3'd3};
  logic [11:0] ex_pcm[3] = '{12'd1, 12'd2, 12'd1};

  initial begin
    int r, p, cen_n, last_acc;
    logic last_cen, pend;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; cen = 1'b1;
    bus.clr = 0; bus.clr_ch = 0; bus.nibble_valid = 0; bus.nibble = 0; bus.ch = 0; bus.lut_inc = 0;
    @(negedge clk);
    chk("rst_vld", 12'(bus.pcm_valid), 12'd0);
    chk("rst_pcm", bus.pcm, 12'd0);
    chk("rst_pcm_ch", 12'(bus.pcm_ch), 12'd0);
    chk("rst_addr", 12'(bus.lut_addr), 12'd0);
    chk("rst_ready", 12'(bus.nibble_ready), 12'd1);
    rst_n = 1'b1;
    cyc();

    // basic add / subtract and step adaptation
    send(3'd0, 4'h7, 12'd30, 9'o007, 12'd30,  1'b1, 0, 3'd0);
    send(3'd0, 4'hF, 12'd69, 9'o117, 12'hFD9, 1'b1, 0, 3'd0);
    send(3'd0, 4'h0, 12'd0,  9'o220, 12'hFD9, 1'b1, 0, 3'd0);

    // step clamp at 0
    pulse_rst();
    send(3'd2, 4'h0, 12'd2, 9'o000, 12'd2, 1'b1, 0, 3'd0);
    send(3'd2, 4'h0, 12'd2, 9'o000, 12'd4, 1'b1, 0, 3'd0);

    // ramp to top step and wrap/saturate
    pulse_rst();
    send(3'd1, 4'h7, 12'd30,   9'o007, 12'd30,   1'b1, 0, 3'd0);
    send(3'd1, 4'h7, 12'd69,   9'o117, 12'd99,   1'b1, 0, 3'd0);
    send(3'd1, 4'h7, 12'd165,  9'o227, 12'd264,  1'b1, 0, 3'd0);
    send(3'd1, 4'h7, 12'd391,  9'o337, 12'd655,  1'b1, 0, 3'd0);
    send(3'd1, 4'h7, 12'd926,  9'o447, 12'd1581, 1'b1, 0, 3'd0);
    send(3'd1, 4'h7, 12'd2186, 9'o557, BIG,      1'b1, 0, 3'd0);
    send(3'd1, 4'h0, 12'd0,    9'o600, BIG,      1'b1, 0, 3'd0);
    send(3'd0, 4'h0, 12'd2,    9'o000, 12'd2,    1'b1, 0, 3'd0);

    // clear interactions (ch1 now step 47)
    send(3'd1, 4'h7, 12'd100, 9'o577, 12'd0,  1'b0, 3, 3'd1);
    send(3'd1, 4'h0, 12'd2,   9'o000, 12'd2,  1'b1, 0, 3'd0);
    send(3'd0, 4'h4, 12'd10,  9'o004, 12'd12, 1'b1, 0, 3'd0);
    send(3'd0, 4'h0, 12'd1,   9'o020, 12'd13, 1'b1, 0, 3'd0);
    send(3'd0, 4'h7, 12'd5,   9'o017, 12'd0,  1'b0, 1, 3'd0);
    send(3'd0, 4'h0, 12'd3,   9'o000, 12'd3,  1'b1, 0, 3'd0);
    send(3'd2, 4'h4, 12'd7,   9'o004, 12'd7,  1'b1, 3, 3'd3);

    // cen 1-of-3 with back-to-back requests, including out-of-range ch=7
    pulse_rst();
    bus.lut_inc = 12'd1; bus.nibble = 4'h0;
    r = 0; p = 0; cen_n = 0; last_acc = -1; last_cen = 1'b0; pend = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (last_cen && bus.pcm_valid) begin
        if (p < 3) begin
          chk("cen_pcm", bus.pcm, ex_pcm[p]);
          chk("cen_pcm_ch", 12'(bus.pcm_ch), 12'(ex_ch[p]));
        end
        p++;
      end
      if (pend) begin r++; pend = 1'b0; end
      bus.nibble_valid = (r < 4);
      bus.ch = rq_ch[r % 4];
      cen = (k % 3 == 0);
      if (cen && bus.nibble_valid && bus.nibble_ready) begin
        pend = 1'b1;
        if (last_acc >= 0) chk("accept_gap", 12'(cen_n - last_acc), 12'd3);
        last_acc = cen_n;
      end
      if (cen) cen_n++;
      last_cen = cen;
      cyc();
    end
    chk("accepted", 12'(r), 12'd4);
    chk("pcm_count", 12'(p), 12'd3);

    // reset while in ACC
    cen = 1'b1; bus.nibble_valid = 1'b1; bus.ch = 3'd0; bus.nibble = 4'h4; bus.lut_inc = 12'd9;
    cyc();
    bus.nibble_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 12'(bus.pcm_valid), 12'd0);
    chk("mid_rst_addr", 12'(bus.lut_addr), 12'd0);
    chk("mid_rst_ready", 12'(bus.nibble_ready), 12'd1);
    #1 rst_n = 1'b1;
    cyc();
    chk("post_rst_vld", 12'(bus.pcm_valid), 12'd0);
    send(3'd0, 4'h4, 12'd3, 9'o004, 12'd3, 1'b1, 0, 3'd0);
    send(3'd3, 4'h5, 12'd1, 9'o005, 12'd1, 1'b1, 0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
